// File: rtl/key_scan.sv
// key_scan: 4x4 active-low keypad scanner with prescaled scan tick, press/release
// debounce and optional auto-repeat.
// Optional feature: define KEY_SCAN_REPEAT_EN to enable auto-repeat of key_valid
// every REP ticks while a key stays held.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating column drive, waiting for any low row
// DEBOUNCE | column frozen, row pattern must stay stable for DEB ticks
// HELD     | key accepted, column frozen until all rows go high
// RELEASE  | rows high, must stay high for DEB ticks to finish release
module key_scan #(
  parameter int N   = 16,
  parameter int DEB = 4,
  parameter int REP = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(DEB + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB);

  // Reject parameter values that make the tick or the counters meaningless.
  if (N < 1 || DEB < 1 || REP < 1) begin : g_bad_param
    $error("key_scan: N, DEB and REP must all be at least 1");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      meta_q, meta_d;
  logic [3:0]      rs_q, rs_d;
  logic [N-1:0]    pre_q, pre_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      col_q, col_d;
  logic [3:0]      pat_q, pat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic [1:0]      row_idx;
  logic            tick;
`ifdef KEY_SCAN_REPEAT_EN
  localparam int RW = $clog2(REP + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
  logic [RW-1:0]   rep_q, rep_d;
`endif

  assign tick    = &pre_q;
  assign cnt_inc = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_q[i]) row_idx = 2'(i);
    end
  end

  // State register and all datapath flops; reset aborts any press in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      meta_q      <= 4'hF;
      rs_q        <= 4'hF;
      pre_q       <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      pat_q       <= 4'hF;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      meta_q      <= meta_d;
      rs_q        <= rs_d;
      pre_q       <= pre_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEY_SCAN_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // Next-state logic; every transition is gated by the scan tick.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        SCAN:     if (rs_q != 4'hF) state_d = DEBOUNCE;
        DEBOUNCE: begin
          if (rs_q != pat_q)          state_d = SCAN;
          else if (cnt_q == DEB_LAST) state_d = HELD;
        end
        HELD:     if (rs_q == 4'hF) state_d = RELEASE;
        RELEASE: begin
          if (rs_q != 4'hF)           state_d = HELD;
          else if (cnt_q == DEB_LAST) state_d = SCAN;
        end
        default:  state_d = SCAN;
      endcase
    end
  end

  // Datapath and registered outputs: synchronizer, prescaler, column, counters, key report.
  always_comb begin
    meta_d      = row;
    rs_d        = meta_q;
    pre_d       = pre_q + 1'b1;
    col_idx_d   = col_idx_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEY_SCAN_REPEAT_EN
    rep_d       = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rs_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            pat_d = rs_q;
            cnt_d = '0;
          end
        end
        DEBOUNCE: begin
          if (rs_q != pat_q) begin
            col_idx_d = col_idx_q + 2'd1;
          end else if (cnt_q == DEB_LAST) begin
            key_code_d  = {row_idx, col_idx_q};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
`ifdef KEY_SCAN_REPEAT_EN
            rep_d       = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HELD: begin
          if (rs_q == 4'hF) begin
            cnt_d = '0;
          end else begin
`ifdef KEY_SCAN_REPEAT_EN
            if (rep_q == REP_LAST) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = rep_q + 1'b1;
            end
`endif
          end
        end
        RELEASE: begin
          if (rs_q != 4'hF) begin
`ifdef KEY_SCAN_REPEAT_EN
            rep_d = '0;
`endif
          end else if (cnt_q == DEB_LAST) begin
            key_held_d = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
    col_d = ~(4'b0001 << col_idx_d);
  end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: a tick-level reference model of the keypad scanner plus a
// 4x4 key matrix that pulls rows low according to the driven column.
module tb_key_scan;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int REP = 8;
  localparam int TICK = 16;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;   // keys[r*4+c] = key at row r, column c is pressed

  int pass_cnt  = 0;
  int total_cnt = 0;
  int valid_cnt = 0;

  key_scan #(.N(N), .DEB(DEB), .REP(REP)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Reference model, evaluated once per clock on the pre-edge values.
  int         m_pre, m_phase, m_col, m_cnt, m_rep;
  logic [3:0] m_s1, m_rs, m_pat, m_code;
  logic       m_valid, m_held;

  function automatic int lowest_low(input logic [3:0] v);
    int idx = 0;
    while (idx < 3 && v[idx]) idx++;
    return idx;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pre = 0; m_phase = 0; m_col = 0; m_cnt = 0; m_rep = 0;
      m_s1 = 4'hF; m_rs = 4'hF; m_pat = 4'hF; m_code = 4'h0;
      m_valid = 1'b0; m_held = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_pre == TICK - 1) begin
        case (m_phase)
          0: if (m_rs == 4'hF) m_col = (m_col + 1) % 4;
             else begin m_pat = m_rs; m_cnt = 0; m_phase = 1; end
          1: if (m_rs != m_pat) begin m_phase = 0; m_col = (m_col + 1) % 4; end
             else begin
               m_cnt++;
               if (m_cnt == DEB) begin
                 m_code  = 4'(lowest_low(m_rs) * 4 + m_col);
                 m_valid = 1'b1; m_held = 1'b1; m_phase = 2; m_rep = 0;
               end
             end
          2: if (m_rs == 4'hF) begin m_phase = 3; m_cnt = 0; end
             else begin
`ifdef KEY_SCAN_REPEAT_EN
               m_rep++;
               if (m_rep == REP) begin m_valid = 1'b1; m_rep = 0; end
`endif
             end
          default: if (m_rs != 4'hF) begin m_phase = 2; m_rep = 0; end
             else begin
               m_cnt++;
               if (m_cnt == DEB) begin m_held = 1'b0; m_col = (m_col + 1) % 4; m_phase = 0; end
             end
        endcase
      end
      m_rs  = m_s1;
      m_s1  = row;
      m_pre = (m_pre + 1) % TICK;
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
  endtask

  // One clock: sample at the falling edge and compare every output against the model.
  task automatic step();
    @(negedge clk);
    if (key_valid) valid_cnt++;
    chk("col",       col,              4'(~(4'b0001 << m_col)));
    chk("key_code",  key_code,         m_code);
    chk("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
    chk("key_held",  {3'b000, key_held},  {3'b000, m_held});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_held(input logic v, input int budget);
    int n = 0;
    while (key_held !== v && n < budget) begin step(); n++; end
    chk("wait_held", {3'b000, key_held}, {3'b000, v});
  endtask

  task automatic wait_col(input logic [3:0] v, input int budget);
    int n = 0;
    while (col !== v && n < budget) begin step(); n++; end
    chk("wait_col", col, v);
  endtask

  logic [3:0] idle_cols [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int base;

  initial begin
    keys  = '0;
    reset = 1'b0;
    steps(3);
    chk("rst_col",   col,      4'b1110);
    chk("rst_code",  key_code, 4'h0);
    chk("rst_valid", {3'b000, key_valid}, 4'h0);
    chk("rst_held",  {3'b000, key_held},  4'h0);
    reset = 1'b1;

    // Idle scan: column advances once per tick.
    for (int k = 0; k < 4; k++) begin
      steps(TICK);
      chk("idle_col", col, idle_cols[k]);
    end
    chk("idle_valid_cnt", 4'(valid_cnt), 4'd0);

    // Clean press of row 2 / column 1.
    base = valid_cnt;
    keys[2*4+1] = 1'b1;
    wait_held(1'b1, 400);
    chk("press_code", key_code, 4'b1001);
    steps(3 * TICK);
    chk("press_pulses", 4'(valid_cnt - base), 4'd1);
    keys = '0;
    wait_held(1'b0, 400);
    chk("release_col", col, 4'b1011);

    // Bounce: key toggles every tick, never stable long enough to accept.
    base = valid_cnt;
    for (int t = 0; t < 10; t++) begin
      keys[2*4+1] = ~keys[2*4+1];
      steps(TICK);
    end
    keys = '0;
    steps(4 * TICK);
    chk("bounce_pulses", 4'(valid_cnt - base), 4'd0);
    chk("bounce_held", {3'b000, key_held}, 4'h0);

    // Two rows on column 0: rows 0 and 3 low, lowest index wins.
    keys[0*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    wait_held(1'b1, 400);
    chk("two_row_code", key_code, 4'b0000);
    // A second key in another column while held must be ignored until release.
    keys[1*4+3] = 1'b1;
    steps(6 * TICK);
    chk("second_key_code", key_code, 4'b0000);
    keys[0*4+0] = 1'b0;
    keys[3*4+0] = 1'b0;
    wait_held(1'b0, 400);
    wait_held(1'b1, 400);
    chk("second_key_after", key_code, 4'b0111);
    keys = '0;
    wait_held(1'b0, 400);

    // Long hold: acceptance plus auto-repeat pulses when enabled.
    base = valid_cnt;
    keys[1*4+2] = 1'b1;
    wait_held(1'b1, 400);
    steps(29 * TICK);
`ifdef KEY_SCAN_REPEAT_EN
    chk("hold_pulses", 4'(valid_cnt - base), 4'd4);
`else
    chk("hold_pulses", 4'(valid_cnt - base), 4'd1);
`endif
    chk("hold_code", key_code, 4'b0110);
    keys = '0;
    wait_held(1'b0, 400);

    // Reset during debounce of row 3 / column 3.
    keys[3*4+3] = 1'b1;
    wait_col(4'b0111, 400);
    steps(TICK + 8);
    chk("pre_reset_held", {3'b000, key_held}, 4'h0);
    base = valid_cnt;
    reset = 1'b0;
    #1;
    chk("mid_rst_col",   col,      4'b1110);
    chk("mid_rst_code",  key_code, 4'h0);
    chk("mid_rst_valid", {3'b000, key_valid}, 4'h0);
    chk("mid_rst_held",  {3'b000, key_held},  4'h0);
    keys = '0;
    steps(3);
    reset = 1'b1;
    steps(12 * TICK);
    chk("post_rst_pulses", 4'(valid_cnt - base), 4'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 The block SHALL have parameter N, default 16, prescaler width; one scan tick occurs every 2^N clk cycles.
REQ-002 The block SHALL have parameter DEB, default 4, the number of stable ticks required to accept a press or a release.
REQ-003 The block SHALL have parameter REP, default 32, the number of ticks between auto-repeat pulses (used only with KEY_SCAN_REPEAT_EN).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The ports SHALL be:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows; active-low; external pull-ups; asynchronous to clk.
- col  output  4  column drive; active-low; one-hot-zero; registered.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key; registered.
- key_valid  output  1  one-clk pulse per accepted press (and per repeat when enabled).
- key_held  output  1  high while an accepted key is held.

Function
REQ-006 row SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized value rs.
REQ-007 An N-bit prescaler SHALL increment every clk; tick SHALL be high for the single cycle in which the prescaler equals all-ones.
REQ-008 The FSM SHALL have four states: SCAN, DEBOUNCE, HELD and RELEASE. All transitions SHALL occur only on tick cycles.
REQ-009 SCAN, rs==4'hF on a tick: col SHALL rotate to the next column (1110->1101->1011->0111->1110).
REQ-010 SCAN, rs!=4'hF on a tick: the FSM SHALL latch col_idx and the row pattern, freeze col, clear the debounce count, and enter DEBOUNCE.
REQ-011 DEBOUNCE, rs differs from the latched pattern on a tick: the FSM SHALL return to SCAN and rotate col.
REQ-012 DEBOUNCE, pattern matches for DEB consecutive ticks: the block SHALL do the following.
- Load key_code; row_idx is the lowest index with rs bit low; multiple rows resolve to the lowest index.
- Pulse key_valid for exactly one cycle.
- Set key_held.
- Enter HELD.
REQ-013 In HELD, col SHALL stay frozen; rs==4'hF on a tick SHALL enter RELEASE with the count cleared.
REQ-014 In RELEASE, rs==4'hF for DEB consecutive ticks SHALL clear key_held, rotate col and enter SCAN.
REQ-015 In RELEASE, any low rs bit on a tick SHALL return the FSM to HELD with no new key_valid.
REQ-016 key_code SHALL hold its value until the next accepted press.
REQ-017 key_valid SHALL never be high for two consecutive cycles.
REQ-018 The debounce counter SHALL be wide enough for DEB and SHALL saturate rather than wrap.
REQ-019 A second key pressed in another column while one is held SHALL be ignored until the release completes.

Reset
REQ-020 While reset is low, outputs SHALL be: col=4'b1110, key_code=4'h0, key_valid=0, key_held=0.
REQ-021 While reset is low, internal state SHALL be: FSM=SCAN, prescaler=0, all counters=0, synchronizer flops=4'hF.
REQ-022 Reset asserted mid-debounce or mid-hold SHALL abort immediately with no key_valid pulse.
REQ-023 Reset deassertion SHALL take effect on the first clk edge after release.

Configuration
REQ-024 With macro KEY_SCAN_REPEAT_EN defined, HELD SHALL count ticks and pulse key_valid (key_code unchanged) every REP ticks after the initial acceptance.
REQ-025 With KEY_SCAN_REPEAT_EN defined, the repeat count SHALL restart on each return from RELEASE to HELD.
REQ-026 Without KEY_SCAN_REPEAT_EN, the repeat counter SHALL be absent and exactly one key_valid SHALL occur per press.

Verification
REQ-027 Bench settings SHALL be N=4 (tick every 16 cycles), DEB=4, REP=8.
REQ-028 Idle scan: rows held 4'hF -> col cycles 1110,1101,1011,0111 every 16 clk; key_valid stays 0.
REQ-029 Clean press: row=4'b1011 while col=4'b1101 -> after 4 stable ticks, one key_valid pulse, key_code=4'b1001, key_held=1; release for 4 ticks -> key_held=0 and scan resumes.
REQ-030 Bounce: row toggles 1011/1111 every tick for 10 ticks -> no key_valid, and col keeps rotating.
REQ-031 Two rows: row=4'b0110 on col 0 -> key_code=4'b0000, i.e. lowest row index wins.
REQ-032 Auto-repeat with macro defined: hold 30 ticks -> key_valid at acceptance, then at +8, +16 and +24 ticks; without the macro -> one pulse only.
REQ-033 Reset: assert reset during DEBOUNCE -> outputs immediately at reset values; no key_valid after deassertion.
